// File: rtl/mem_pkg.sv
// Shared MEM-stage types: load/store encodings, FSM states and access-size helper.
package mem_pkg;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LD  = 3'b011,
    LBU = 3'b100,
    LHU = 3'b101,
    LWU = 3'b110
  } loadTypeE;

  typedef enum logic [1:0] {
    SB = 2'b00,
    SH = 2'b01,
    SW = 2'b10,
    SD = 2'b11
  } storeTypeE;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    DONE = 2'b10
  } stateE;

  // log2 of the access size in bytes
  function automatic logic [1:0] size_of(input logic isLoad, input logic [2:0] accType);
    if (isLoad) begin
      case (loadTypeE'(accType))
        LB, LBU: size_of = 2'd0;
        LH, LHU: size_of = 2'd1;
        LW, LWU: size_of = 2'd2;
        default: size_of = 2'd3;
      endcase
    end else begin
      size_of = accType[1:0];
    end
  endfunction

endpackage

// File: rtl/load_align.sv
// Lane select and sign/zero extension of a 64-bit read doubleword.
module load_align
  import mem_pkg::*;
(
  input  logic [63:0] rdata,
  input  logic [2:0]  addr,
  input  logic [2:0]  loadType,
  output logic [63:0] value
);

  logic [63:0] shifted;

  always_comb begin
    shifted = rdata >> {addr, 3'b000};
    case (loadTypeE'(loadType))
      LB:      value = {{56{shifted[7]}}, shifted[7:0]};
      LH:      value = {{48{shifted[15]}}, shifted[15:0]};
      LW:      value = {{32{shifted[31]}}, shifted[31:0]};
      LBU:     value = {56'd0, shifted[7:0]};
      LHU:     value = {48'd0, shifted[15:0]};
      LWU:     value = {32'd0, shifted[31:0]};
      default: value = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MEM stage: data-cache request/ack handshake, store/load alignment, MEM/WB register.
module mem_access
  import mem_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [BUS_DATA_WIDTH-1:0] inResult,
  input  logic [BUS_DATA_WIDTH-1:0] inDataReg2,
  input  logic                      inMemRead,
  input  logic                      inMemWrite,
  input  logic                      inRegWrite,
  input  logic                      inMemOrReg,
  input  logic [2:0]                inLoadType,
  input  logic [1:0]                inStoreType,
  input  logic [4:0]                inDestRegister,
  input  logic                      in_stall_from_icache,
  output logic                      out_dc_req,
  output logic                      out_dc_we,
  output logic [BUS_DATA_WIDTH-1:0] out_dc_addr,
  output logic [BUS_DATA_WIDTH-1:0] out_dc_wdata,
  output logic [7:0]                out_dc_wstrb,
  input  logic                      in_dc_ack,
  input  logic [BUS_DATA_WIDTH-1:0] in_dc_rdata,
  output logic                      out_stall_from_dcache,
  output logic                      out_misaligned,
  output logic [BUS_DATA_WIDTH-1:0] outResultMem,
  output logic                      outRegWrite,
  output logic [4:0]                outDestRegister
);

  stateE                     state, stateNext;
  logic                      access, offAlign, misalignedNow, legal, update;
  logic [1:0]                accSize;
  logic [BUS_DATA_WIDTH-1:0] alignedLoad, loadHeld, loadValue, storeData;
  logic [7:0]                storeStrb;

  assign access  = inMemRead | inMemWrite;
  assign accSize = size_of(inMemRead, inMemRead ? inLoadType : {1'b0, inStoreType});

  always_comb begin
    case (accSize)
      2'd0:    offAlign = 1'b0;
      2'd1:    offAlign = inResult[0];
      2'd2:    offAlign = |inResult[1:0];
      default: offAlign = |inResult[2:0];
    endcase
  end

  assign misalignedNow = access & offAlign;
  assign legal         = access & ~offAlign;

  always_comb begin
    stateNext             = state;
    out_stall_from_dcache = 1'b0;
    case (state)
      IDLE: begin
        if (legal) begin
          stateNext             = WAIT;
          out_stall_from_dcache = 1'b1;
        end
      end
      WAIT: begin
        if (in_dc_ack) stateNext = in_stall_from_icache ? DONE : IDLE;
        else           out_stall_from_dcache = 1'b1;
      end
      DONE: begin
        if (!in_stall_from_icache) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  assign update = ~out_stall_from_dcache & ~in_stall_from_icache;

  // Low bytes are replicated across the doubleword; the strobe picks the live lane.
  always_comb begin
    case (storeTypeE'(inStoreType))
      SB: begin
        storeData = {8{inDataReg2[7:0]}};
        storeStrb = 8'h01 << inResult[2:0];
      end
      SH: begin
        storeData = {4{inDataReg2[15:0]}};
        storeStrb = 8'h03 << inResult[2:0];
      end
      SW: begin
        storeData = {2{inDataReg2[31:0]}};
        storeStrb = 8'h0F << inResult[2:0];
      end
      default: begin
        storeData = inDataReg2;
        storeStrb = 8'hFF;
      end
    endcase
  end

  load_align u_loadAlign (
    .rdata    (in_dc_rdata),
    .addr     (inResult[2:0]),
    .loadType (inLoadType),
    .value    (alignedLoad)
  );

  // Live read data on the ack edge; otherwise the value captured when leaving WAIT.
  assign loadValue = (state == WAIT) ? alignedLoad : loadHeld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      out_dc_req   <= 1'b0;
      out_dc_we    <= 1'b0;
      out_dc_addr  <= '0;
      out_dc_wdata <= '0;
      out_dc_wstrb <= '0;
      loadHeld     <= '0;
    end else begin
      state <= stateNext;
      if (state == IDLE && legal) begin
        out_dc_req   <= 1'b1;
        out_dc_we    <= ~inMemRead;
        out_dc_addr  <= {inResult[BUS_DATA_WIDTH-1:3], 3'b000};
        out_dc_wdata <= inMemRead ? '0 : storeData;
        out_dc_wstrb <= inMemRead ? '0 : storeStrb;
      end else if (state == WAIT && in_dc_ack) begin
        out_dc_req <= 1'b0;
        out_dc_we  <= 1'b0;
        loadHeld   <= alignedLoad;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_misaligned  <= 1'b0;
      outResultMem    <= '0;
      outRegWrite     <= 1'b0;
      outDestRegister <= '0;
    end else begin
      out_misaligned <= update & misalignedNow;
      if (update) begin
        outResultMem    <= inMemOrReg ? loadValue : inResult;
        outRegWrite     <= inRegWrite & ~misalignedNow;
        outDestRegister <= inDestRegister;
      end
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed self-checking bench for mem_access.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] inResult, inDataReg2;
  logic        inMemRead, inMemWrite, inRegWrite, inMemOrReg;
  logic [2:0]  inLoadType;
  logic [1:0]  inStoreType;
  logic [4:0]  inDestRegister;
  logic        in_stall_from_icache;
  logic        out_dc_req, out_dc_we;
  logic [63:0] out_dc_addr, out_dc_wdata;
  logic [7:0]  out_dc_wstrb;
  logic        in_dc_ack;
  logic [63:0] in_dc_rdata;
  logic        out_stall_from_dcache, out_misaligned;
  logic [63:0] outResultMem;
  logic        outRegWrite;
  logic [4:0]  outDestRegister;

  int unsigned nAsserts = 0;
  int unsigned nFail    = 0;

  always #5 clk = ~clk;

  mem_access #(.BUS_DATA_WIDTH(64)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .inResult              (inResult),
    .inDataReg2            (inDataReg2),
    .inMemRead             (inMemRead),
    .inMemWrite            (inMemWrite),
    .inRegWrite            (inRegWrite),
    .inMemOrReg            (inMemOrReg),
    .inLoadType            (inLoadType),
    .inStoreType           (inStoreType),
    .inDestRegister        (inDestRegister),
    .in_stall_from_icache  (in_stall_from_icache),
    .out_dc_req            (out_dc_req),
    .out_dc_we             (out_dc_we),
    .out_dc_addr           (out_dc_addr),
    .out_dc_wdata          (out_dc_wdata),
    .out_dc_wstrb          (out_dc_wstrb),
    .in_dc_ack             (in_dc_ack),
    .in_dc_rdata           (in_dc_rdata),
    .out_stall_from_dcache (out_stall_from_dcache),
    .out_misaligned        (out_misaligned),
    .outResultMem          (outResultMem),
    .outRegWrite           (outRegWrite),
    .outDestRegister       (outDestRegister)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nAsserts++;
    assert (obs === exp)
    else begin
      nFail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clearInputs();
    inResult       = '0;
    inDataReg2     = '0;
    inMemRead      = 1'b0;
    inMemWrite     = 1'b0;
    inRegWrite     = 1'b0;
    inMemOrReg     = 1'b0;
    inLoadType     = '0;
    inStoreType    = '0;
    inDestRegister = '0;
  endtask

  // Present a load, ack it after waitCycles request cycles, let MEM/WB take it.
  task automatic doLoad(input logic [63:0] addr, input logic [2:0] lt, input logic [63:0] rdata,
                        input int unsigned waitCycles, input logic [4:0] dest);
    tick();
    inMemRead = 1'b1; inLoadType = lt; inResult = addr;
    inRegWrite = 1'b1; inMemOrReg = 1'b1; inDestRegister = dest;
    @(negedge clk);
    chk("ld_stall_N", out_stall_from_dcache, 1'b1);
    chk("ld_noreq_N", out_dc_req, 1'b0);
    tick();
    for (int unsigned i = 0; i < waitCycles; i++) begin
      @(negedge clk);
      chk("ld_stall_wait", out_stall_from_dcache, 1'b1);
      chk("ld_req_wait", out_dc_req, 1'b1);
      tick();
    end
    in_dc_ack = 1'b1; in_dc_rdata = rdata;
    @(negedge clk);
    chk("ld_stall_ack", out_stall_from_dcache, 1'b0);
    tick();
    in_dc_ack = 1'b0;
    clearInputs();
    @(negedge clk);
  endtask

  initial begin
    #50000;
    $display("FAIL timeout: observed no end of test, expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    in_stall_from_icache = 1'b0;
    in_dc_ack = 1'b0;
    in_dc_rdata = '0;
    clearInputs();
    @(negedge clk);
    @(negedge clk);
    chk("rst_req", out_dc_req, 1'b0);
    chk("rst_stall", out_stall_from_dcache, 1'b0);
    chk("rst_result", outResultMem, 64'h0);
    chk("rst_regwrite", outRegWrite, 1'b0);
    chk("rst_misaligned", out_misaligned, 1'b0);
    rst_n = 1'b1;

    // Aligned ld, ack three cycles after the request: stall N..N+3.
    doLoad(64'h1000, 3'b011, 64'h8877665544332211, 3, 5'd5);
    chk("ld_result", outResultMem, 64'h8877665544332211);
    chk("ld_regwrite", outRegWrite, 1'b1);
    chk("ld_dest", outDestRegister, 5'd5);
    chk("ld_req_done", out_dc_req, 1'b0);

    doLoad(64'h1003, 3'b000, 64'h00000000F0000000, 1, 5'd6);
    chk("lb_result", outResultMem, 64'hFFFFFFFFFFFFFFF0);
    doLoad(64'h1003, 3'b100, 64'h00000000F0000000, 1, 5'd7);
    chk("lbu_result", outResultMem, 64'h00000000000000F0);
    doLoad(64'h1004, 3'b010, 64'h8000000012345678, 0, 5'd8);
    chk("lw_hi_result", outResultMem, 64'hFFFFFFFF80000000);
    doLoad(64'h1002, 3'b101, 64'h00000000ABCD0000, 1, 5'd9);
    chk("lhu_result", outResultMem, 64'h000000000000ABCD);

    // sh at 0x2006
    tick();
    inMemWrite = 1'b1; inStoreType = 2'b01; inDataReg2 = 64'hABCD; inResult = 64'h2006;
    @(negedge clk);
    chk("sh_stall_N", out_stall_from_dcache, 1'b1);
    tick();
    @(negedge clk);
    chk("sh_req", out_dc_req, 1'b1);
    chk("sh_we", out_dc_we, 1'b1);
    chk("sh_addr", out_dc_addr, 64'h2000);
    chk("sh_wstrb", out_dc_wstrb, 8'hC0);
    chk("sh_wdata", out_dc_wdata, 64'hABCDABCDABCDABCD);
    tick();
    in_dc_ack = 1'b1;
    tick();
    in_dc_ack = 1'b0;
    clearInputs();
    @(negedge clk);
    chk("sh_result", outResultMem, 64'h2006);
    chk("sh_regwrite", outRegWrite, 1'b0);
    chk("sh_req_done", out_dc_req, 1'b0);

    // sb at 0x2003 with junk above the low byte
    tick();
    inMemWrite = 1'b1; inStoreType = 2'b00; inDataReg2 = 64'h123456789ABCDE5A; inResult = 64'h2003;
    tick();
    @(negedge clk);
    chk("sb_wstrb", out_dc_wstrb, 8'h08);
    chk("sb_wdata", out_dc_wdata, 64'h5A5A5A5A5A5A5A5A);
    chk("sb_addr", out_dc_addr, 64'h2000);
    tick();
    in_dc_ack = 1'b1;
    tick();
    in_dc_ack = 1'b0;
    clearInputs();
    @(negedge clk);

    // Misaligned lw at 0x3002
    tick();
    inMemRead = 1'b1; inLoadType = 3'b010; inResult = 64'h3002; inRegWrite = 1'b1;
    @(negedge clk);
    chk("mis_stall", out_stall_from_dcache, 1'b0);
    tick();
    clearInputs();
    @(negedge clk);
    chk("mis_pulse", out_misaligned, 1'b1);
    chk("mis_regwrite", outRegWrite, 1'b0);
    chk("mis_noreq", out_dc_req, 1'b0);
    tick();
    @(negedge clk);
    chk("mis_pulse_end", out_misaligned, 1'b0);
    chk("mis_noreq2", out_dc_req, 1'b0);

    // Ack with icache stall -> DONE, no reissue, single MEM/WB update.
    chk("ic_prior", outResultMem, 64'h0);
    tick();
    inMemRead = 1'b1; inLoadType = 3'b011; inResult = 64'h5008;
    inRegWrite = 1'b1; inMemOrReg = 1'b1; inDestRegister = 5'd12;
    tick();
    in_dc_ack = 1'b1; in_stall_from_icache = 1'b1; in_dc_rdata = 64'h1122334455667788;
    @(negedge clk);
    chk("ic_stall_ack", out_stall_from_dcache, 1'b0);
    tick();
    in_dc_ack = 1'b0;
    for (int unsigned i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("ic_done_noreq", out_dc_req, 1'b0);
      chk("ic_done_nostall", out_stall_from_dcache, 1'b0);
      chk("ic_done_hold", outResultMem, 64'h0);
      tick();
    end
    in_stall_from_icache = 1'b0;
    @(negedge clk);
    chk("ic_release_noupd", outResultMem, 64'h0);
    tick();
    clearInputs();
    @(negedge clk);
    chk("ic_result", outResultMem, 64'h1122334455667788);
    chk("ic_dest", outDestRegister, 5'd12);
    chk("ic_noreq", out_dc_req, 1'b0);

    // Reset during WAIT
    tick();
    inMemRead = 1'b1; inLoadType = 3'b011; inResult = 64'h6000; inMemOrReg = 1'b1; inRegWrite = 1'b1;
    tick();
    chk("rw_req_before", out_dc_req, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rw_req_async", out_dc_req, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    clearInputs();
    inMemOrReg = 1'b1;
    in_dc_ack = 1'b1; in_dc_rdata = 64'hDEADBEEFDEADBEEF;
    tick();
    in_dc_ack = 1'b0;
    inMemOrReg = 1'b0;
    @(negedge clk);
    chk("rw_ack_ignored", outResultMem, 64'h0);
    chk("rw_noreq", out_dc_req, 1'b0);
    doLoad(64'h6008, 3'b011, 64'h0123456789ABCDEF, 1, 5'd3);
    chk("rw_next_result", outResultMem, 64'h0123456789ABCDEF);
    chk("rw_next_regwrite", outRegWrite, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule
